// File: rtl/catch_pkg.sv
// Shared widths, divider length and FSM state type for the glove tracker.
package catch_pkg;
  localparam int HC_W      = 11;
  localparam int VC_W      = 10;
  localparam int CNT_W     = 20;
  localparam int SUM_W     = 30;
  localparam int DIV_ITERS = 30;
  localparam int ITER_W    = $clog2(DIV_ITERS);

  typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} loc_state_e;
endpackage

// File: rtl/seq_divider.sv
// Restoring radix-2 divider, one quotient bit per cycle.
// 'start' loads operands (and restarts a running division). 'done' is
// high during the final iteration cycle, with 'quotient' presenting the
// finished result combinationally, so a follow-on division can be
// started in the same cycle without a bubble.
module seq_divider
  import catch_pkg::*;
#(
  parameter int Q_W = HC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             done,
  output logic [Q_W-1:0]   quotient
);
  localparam logic [ITER_W-1:0] LAST = ITER_W'(DIV_ITERS - 1);

  logic [SUM_W-1:0]  dvd_q, dvd_d;   // dividend shifts out, quotient shifts in
  logic [CNT_W-1:0]  dsr_q;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [ITER_W-1:0] iter_q;
  logic              run_q;
  logic [CNT_W:0]    rem_sh;
  logic              ge;

  // One restoring step. The remainder stays below the divisor, so the
  // subtraction can be done modulo 2^CNT_W.
  always_comb begin
    rem_sh = {rem_q, dvd_q[SUM_W-1]};
    ge     = (rem_sh >= {1'b0, dsr_q});
    rem_d  = ge ? (rem_sh[CNT_W-1:0] - dsr_q) : rem_sh[CNT_W-1:0];
    dvd_d  = {dvd_q[SUM_W-2:0], ge};
  end

  assign done     = run_q && (iter_q == LAST);
  assign quotient = dvd_d[Q_W-1:0];

  // Operand load on start, otherwise iterate until the last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q  <= '0;
      dsr_q  <= '0;
      rem_q  <= '0;
      iter_q <= '0;
      run_q  <= 1'b0;
    end else if (start) begin
      dvd_q  <= dividend;
      dsr_q  <= divisor;
      rem_q  <= '0;
      iter_q <= '0;
      run_q  <= 1'b1;
    end else if (run_q) begin
      dvd_q  <= dvd_d;
      rem_q  <= rem_d;
      iter_q <= iter_q + 1'b1;
      if (iter_q == LAST) run_q <= 1'b0;
    end
  end
endmodule

// File: rtl/glove_locator.sv
// Glove tracker: colour-window match on the pixel stream, per-frame
// area/coordinate sums, and a centroid computed at each frame end by a
// single shared sequential divider (X then Y).
module glove_locator
  import catch_pkg::*;
#(
  parameter logic [7:0] R_MIN       = 8'hC0,
  parameter logic [7:0] G_MAX       = 8'h40,
  parameter logic [7:0] B_MAX       = 8'h40,
  parameter int         MIN_PIXELS  = 64,
  parameter int         CLOSED_AREA = 2048
) (
  input  logic            vclock,
  input  logic            reset_n,
  input  logic [HC_W-1:0] hcount,
  input  logic [VC_W-1:0] vcount,
  input  logic            vsync,
  input  logic            blank,
  input  logic [23:0]     pixel,
  output logic [HC_W-1:0] glove_x,
  output logic [VC_W-1:0] glove_y,
  output logic            glove_found,
  output logic            glove_closed,
  output logic            coord_valid,
  output logic            busy,
  output logic            overrun
);
  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_PIXELS);
  localparam logic [CNT_W-1:0] CLOSED_C = CNT_W'(CLOSED_AREA);

  logic             vsync_q;
  logic [CNT_W-1:0] cnt_q, snap_cnt_q;
  logic [SUM_W-1:0] sx_q, sy_q, snap_sy_q;
  loc_state_e       state_q;
  logic [HC_W-1:0]  qx_q, gx_q;
  logic [VC_W-1:0]  gy_q;
  logic             found_q, closed_q, valid_q, overrun_q;

  logic             match, frame_end, found_now;
  logic             div_start, div_done;
  logic [SUM_W-1:0] div_dvd;
  logic [CNT_W-1:0] div_dsr;
  logic [HC_W-1:0]  div_q;

  assign match     = !blank && (pixel[23:16] >= R_MIN) &&
                     (pixel[15:8] <= G_MAX) && (pixel[7:0] <= B_MAX);
  assign frame_end = vsync_q && !vsync;
  assign found_now = (cnt_q >= MIN_C);

  // Divider feed: X starts straight from the live accumulators at the
  // frame end; Y starts from the snapshot as X finishes.
  always_comb begin
    div_start = 1'b0;
    div_dvd   = sx_q;
    div_dsr   = cnt_q;
    if (frame_end) begin
      div_start = found_now;
    end else if (state_q == DIV_X && div_done) begin
      div_start = 1'b1;
      div_dvd   = snap_sy_q;
      div_dsr   = snap_cnt_q;
    end
  end

  // Per-frame accumulation; a match in the frame-end cycle seeds the new frame.
  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q <= 1'b0;
      cnt_q   <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
    end else begin
      vsync_q <= vsync;
      if (frame_end) begin
        cnt_q <= match ? CNT_W'(1) : '0;
        sx_q  <= match ? SUM_W'(hcount) : '0;
        sy_q  <= match ? SUM_W'(vcount) : '0;
      end else if (match) begin
        cnt_q <= cnt_q + 1'b1;
        sx_q  <= sx_q + SUM_W'(hcount);
        sy_q  <= sy_q + SUM_W'(vcount);
      end
    end
  end

  // Control FSM with registered outputs. A frame end overrides any state.
  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      snap_cnt_q <= '0;
      snap_sy_q  <= '0;
      qx_q       <= '0;
      gx_q       <= '0;
      gy_q       <= '0;
      found_q    <= 1'b0;
      closed_q   <= 1'b0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (frame_end) begin
        if (state_q != IDLE) overrun_q <= 1'b1;
        snap_cnt_q <= cnt_q;
        snap_sy_q  <= sy_q;
        if (found_now) begin
          state_q <= DIV_X;
        end else begin
          state_q  <= DONE;
          found_q  <= 1'b0;
          closed_q <= 1'b0;
          valid_q  <= 1'b1;
        end
      end else begin
        case (state_q)
          DIV_X: if (div_done) begin
            qx_q    <= div_q;
            state_q <= DIV_Y;
          end
          DIV_Y: if (div_done) begin
            gx_q     <= qx_q;
            gy_q     <= div_q[VC_W-1:0];
            found_q  <= 1'b1;
            closed_q <= (snap_cnt_q < CLOSED_C);
            valid_q  <= 1'b1;
            state_q  <= DONE;
          end
          DONE:    state_q <= IDLE;
          default: ;
        endcase
      end
    end
  end

  seq_divider #(.Q_W(HC_W)) u_div (
    .clk      (vclock),
    .rst_n    (reset_n),
    .start    (div_start),
    .dividend (div_dvd),
    .divisor  (div_dsr),
    .done     (div_done),
    .quotient (div_q)
  );

  assign glove_x      = gx_q;
  assign glove_y      = gy_q;
  assign glove_found  = found_q;
  assign glove_closed = closed_q;
  assign coord_valid  = valid_q;
  assign busy         = (state_q != IDLE);
  assign overrun      = overrun_q;
endmodule

// File: tb/tb_glove_locator.sv
// Directed bench for glove_locator: frame vectors from a table plus
// hand-written overrun and mid-division reset sequences.
module tb_glove_locator;
  logic        vclock = 1'b0;
  logic        reset_n = 1'b1;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic        vsync = 1'b1;
  logic        blank = 1'b1;
  logic [23:0] pixel = '0;

  logic [10:0] gx_a, gx_b;
  logic [9:0]  gy_a, gy_b;
  logic        fnd_a, fnd_b, cls_a, cls_b, val_a, val_b, bsy_a, bsy_b, ovr_a, ovr_b;

  int n_cmp = 0;
  int n_bad = 0;

  glove_locator u_dut (
    .vclock(vclock), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
    .vsync(vsync), .blank(blank), .pixel(pixel),
    .glove_x(gx_a), .glove_y(gy_a), .glove_found(fnd_a), .glove_closed(cls_a),
    .coord_valid(val_a), .busy(bsy_a), .overrun(ovr_a)
  );

  // Low found threshold so a short frame between two frame ends is "found".
  glove_locator #(.MIN_PIXELS(8)) u_ovr (
    .vclock(vclock), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
    .vsync(vsync), .blank(blank), .pixel(pixel),
    .glove_x(gx_b), .glove_y(gy_b), .glove_found(fnd_b), .glove_closed(cls_b),
    .coord_valid(val_b), .busy(bsy_b), .overrun(ovr_b)
  );

  always #5 vclock = ~vclock;

  typedef struct {
    int          x0, x1, y0, y1;
    logic [23:0] px;
    int          nbad;
    int          lat, found, closed, ex, ey;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge vclock);
    #1;
  endtask

  task automatic draw(input int x0, input int x1, input int y0, input int y1,
                      input logic [23:0] px);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) begin
        hcount = 11'(x);
        vcount = 10'(y);
        pixel  = px;
        blank  = 1'b0;
        tick();
      end
    blank = 1'b1;
    pixel = '0;
  endtask

  // Draw one frame, end it, and report on the first coord_valid of u_dut.
  task automatic run_vec(input int i, input vec_t v);
    int lat, cx, cy, cf, cc, b1;
    vsync = 1'b1;
    blank = 1'b1;
    tick();
    draw(v.x0, v.x1, v.y0, v.y1, v.px);
    if (v.nbad > 0) draw(500, 500 + v.nbad - 1, 500, 500, 24'hBF4040);
    vsync = 1'b0;                   // this cycle is E
    tick();
    lat = -1; cx = 0; cy = 0; cf = 0; cc = 0; b1 = 0;
    for (int k = 1; k <= 100; k++) begin
      if (k == 2) vsync = 1'b1;
      if (k == 1) b1 = int'(bsy_a);
      if (lat < 0 && val_a) begin
        lat = k; cx = int'(gx_a); cy = int'(gy_a); cf = int'(fnd_a); cc = int'(cls_a);
      end
      tick();
    end
    chk($sformatf("v%0d busy@E+1", i), b1, 1);
    chk($sformatf("v%0d latency", i), lat, v.lat);
    chk($sformatf("v%0d found", i), cf, v.found);
    chk($sformatf("v%0d closed", i), cc, v.closed);
    chk($sformatf("v%0d x", i), cx, v.ex);
    chk($sformatf("v%0d y", i), cy, v.ey);
  endtask

  initial begin
    int fa, fb, nb, ca, bx, by, bf, bc;

    vecs[0] = '{100, 109, 200, 209, 24'hFF0000, 0, 61, 1, 1, 104, 204};
    vecs[1] = '{300, 363, 400, 463, 24'hFF0000, 0, 61, 1, 0, 331, 431};
    vecs[2] = '{0,   9,   0,   9,   24'h000000, 0, 1,  0, 0, 331, 431};
    vecs[3] = '{10,  72,  50,  50,  24'hC04040, 5, 1,  0, 0, 331, 431};
    vecs[4] = '{10,  73,  50,  50,  24'hC04040, 5, 61, 1, 1, 41,  50};

    // reset state
    #2 reset_n = 1'b0;
    tick(); tick();
    chk("rst glove_x", int'(gx_a), 0);
    chk("rst glove_y", int'(gy_a), 0);
    chk("rst found", int'(fnd_a), 0);
    chk("rst closed", int'(cls_a), 0);
    chk("rst coord_valid", int'(val_a), 0);
    chk("rst busy", int'(bsy_a), 0);
    chk("rst overrun", int'(ovr_a), 0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);
    chk("no overrun after table", int'(ovr_a), 0);

    // Overrun: second frame end 20 cycles after the first.
    vsync = 1'b1;
    tick();
    draw(100, 109, 200, 209, 24'hFF0000);
    vsync = 1'b0;                   // E1
    tick();
    fa = -1; fb = -1; nb = 0; ca = 0; bx = 0; by = 0; bf = 0; bc = 0;
    for (int k = 1; k <= 100; k++) begin
      vsync = (k == 20) ? 1'b0 : 1'b1;
      if (k >= 2 && k <= 17) begin
        hcount = 11'(20 + k - 2);
        vcount = 10'd60;
        pixel  = 24'hFF0000;
        blank  = 1'b0;
      end else begin
        blank = 1'b1;
        pixel = '0;
      end
      if (val_b) begin
        nb++;
        if (fb < 0) begin
          fb = k; bx = int'(gx_b); by = int'(gy_b); bf = int'(fnd_b); bc = int'(cls_b);
        end
      end
      if (val_a && fa < 0) begin
        fa = k; ca = int'(fnd_a);
      end
      tick();
    end
    blank = 1'b1;
    chk("ovr overrun flag", int'(ovr_b), 1);
    chk("ovr pulse count", nb, 1);
    chk("ovr pulse cycle", fb, 81);
    chk("ovr x", bx, 27);
    chk("ovr y", by, 60);
    chk("ovr found", bf, 1);
    chk("ovr closed", bc, 1);
    chk("main overrun flag", int'(ovr_a), 1);
    chk("main short-frame pulse", fa, 21);
    chk("main short-frame found", ca, 0);

    // Reset in the middle of a division.
    vsync = 1'b1;
    tick();
    draw(100, 109, 200, 209, 24'hFF0000);
    vsync = 1'b0;                   // E
    tick();
    nb = 0;
    for (int k = 1; k <= 100; k++) begin
      if (k == 2) vsync = 1'b1;
      if (k == 30) begin
        reset_n = 1'b0;
        #1;
        chk("midrst glove_x", int'(gx_a), 0);
        chk("midrst glove_y", int'(gy_a), 0);
        chk("midrst found", int'(fnd_a), 0);
        chk("midrst closed", int'(cls_a), 0);
        chk("midrst busy", int'(bsy_a), 0);
        chk("midrst overrun", int'(ovr_a), 0);
      end
      if (k == 32) reset_n = 1'b1;
      if (val_a) nb++;
      tick();
    end
    chk("midrst no pulse", nb, 0);
    run_vec(5, vecs[1]);
    chk("post-reset overrun", int'(ovr_a), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/glove_locator.md
# glove_locator

Video-side glove tracker for the catch game. It takes the camera pixel stream on the same raster timing used by the game renderer (`hcount`/`vcount`/`vsync`/`blank`). It classifies each active pixel against a glove colour window and accumulates per-frame area and coordinate sums. At each frame end it computes the glove centroid with a shared sequential divider. It reports the glove coordinates and an open/closed decision, which feed the coordinate and ball logic upstream of the renderer.

## Interface
Parameters:
- `R_MIN`, 8'hC0, minimum red component for a match (inclusive)
- `G_MAX`, 8'h40, maximum green component for a match (inclusive)
- `B_MAX`, 8'h40, maximum blue component for a match (inclusive)
- `MIN_PIXELS`, 64, minimum matched count for `glove_found`; must be ≥1
- `CLOSED_AREA`, 2048, a found glove with count below this is reported closed

Ports:
- `vclock`  in  1  27 MHz pixel clock; the only clock
- `reset_n`  in  1  asynchronous, active-low reset
- `hcount`  in  11  horizontal pixel index
- `vcount`  in  10  vertical pixel index
- `vsync`  in  1  active-low vertical sync, synchronous to `vclock`
- `blank`  in  1  1 = non-active pixel; the pixel is ignored
- `pixel`  in  24  camera pixel, r=23:16, g=15:8, b=7:0
- `glove_x`  out  11  centroid x, truncated
- `glove_y`  out  10  centroid y, truncated
- `glove_found`  out  1  count ≥ `MIN_PIXELS` in the last reported frame
- `glove_closed`  out  1  found and count < `CLOSED_AREA`
- `coord_valid`  out  1  one-cycle pulse when the outputs update
- `busy`  out  1  divider FSM not IDLE
- `overrun`  out  1  sticky; a frame end arrived while busy

## Operation
- **Match:** `blank==0` and r≥`R_MIN` and g≤`G_MAX` and b≤`B_MAX`.
- **Accumulate on each match:** `cnt += 1` (20 b), `sum_x += hcount` (30 b), `sum_y += vcount` (30 b). The widths cover a full 1024×768 frame with no overflow.
- **Frame end:** cycle E, where registered `vsync` is 1 and the current `vsync` is 0.
  - At E, snapshot `cnt`, `sum_x` and `sum_y`, and clear the accumulators.
  - A match in cycle E goes to the new frame.
- **FSM states:** IDLE, DIV_X, DIV_Y, DONE.
  - IDLE → DIV_X at E if snapshot count ≥ `MIN_PIXELS`; otherwise IDLE → DONE.
  - DIV_X runs 30 iterations of `sum_x/cnt`, then goes to DIV_Y.
  - DIV_Y runs 30 iterations of `sum_y/cnt`, then goes to DONE.
  - DONE registers the outputs, pulses `coord_valid`, and returns to IDLE.
- **Not-found frame:** `glove_found=0`, `glove_closed=0`, and `glove_x`/`glove_y` hold their previous values.
- **Found frame:**
  - `glove_x` = quotient[10:0] and `glove_y` = quotient[9:0]; the quotient is always in range.
  - `glove_closed` = (count < `CLOSED_AREA`).
- **Frame end while busy:** abort the current division, take the new snapshot, restart from the IDLE decision, and set `overrun`. The aborted frame produces no `coord_valid`.
- **`reset_n` low at any time:** all state and accumulators clear. Outputs reset to 0: `glove_x`, `glove_y`, `glove_found`, `glove_closed`, `coord_valid`, `busy`, `overrun`. No pulse follows a division interrupted by reset.

## Timing
- Found frame: `coord_valid` is high in cycle E+61, giving 1 cycle DIV_X entry plus 30+30 iterations.
- Not-found frame: `coord_valid` is high in cycle E+1.
- `glove_*` change only in the cycle `coord_valid` is high and are stable otherwise.
- `busy` is high from E+1 through the DONE cycle.
- The accumulator path is single-cycle. There is no pixel backpressure; every pixel is consumed.

## Structure
- **Shared package `catch_pkg`:**
  - Width constants: `HC_W=11`, `VC_W=10`, `CNT_W=20`, `SUM_W=30`.
  - `DIV_ITERS=30`.
  - The FSM state typedef.
- **Sub-module `seq_divider`:**
  - Restoring radix-2 divider, 30-bit dividend / 20-bit divisor.
  - `start`/`done` handshake; `start` while running restarts it.
  - Instantiated once and shared between the X and Y divisions.

## Test plan
- Red 10×10 square, x 100..109, y 200..209, in one frame → at E+61: `coord_valid`=1, x=104, y=204, `glove_found`=1, `glove_closed`=1.
- Red 64×64 square, x 300..363, y 400..463 → x=331, y=431, found=1, closed=0 (count 4096).
- Next frame all black → `coord_valid` at E+1, found=0, closed=0, x/y hold 331/431.
- Threshold boundary: pixel r=8'hC0, g=b=8'h40 matches; r=8'hBF does not.
  - 63 matches → found=0.
  - 64 matches → found=1.
- Second `vsync` fall at E+20 → `overrun`=1, no pulse at E+61, pulse at (E+20)+61 carrying the second frame's result.
- `reset_n` low at E+30 → all outputs 0 immediately, no `coord_valid`; the next frame reports normally.
